byte_array_streamer: RTL

Parametrised successor to the team's fixed 4-byte array processor. It stores a word of `NUM_BYTES` bytes with per-byte write strobes and keeps a combinational random-access read path with parity and nibble outputs. It also serialises a snapshot of the stored word onto a valid/ready byte stream, LSB-first or MSB-first. It sits between a word-wide register interface and a byte-wide downstream consumer such as a UART or SPI shifter.

---
 rtl/byte_array_streamer.sv | 98 +++++++++
 1 files changed

// File: rtl/byte_array_streamer.sv
// byte_array_streamer: strobed byte-array word register with random-access read path and valid/ready byte streamer
// Parameters:
//   NUM_BYTES  bytes per word (>= 2)
//   SEL_W      byte select / stream index width, derived from NUM_BYTES
// Ports:
//   clock, reset                       clock, asynchronous active-high reset
//   data_word, write_enable,
//   byte_strobe                        strobed word write into storage
//   byte_select -> selected_byte,
//   byte_parity, nibble_high,
//   nibble_low, word_parity            combinational read path from storage
//   start, msb_first                   request a frame of the current storage word
//   stream_byte, stream_parity,
//   stream_valid, stream_ready,
//   stream_last                        valid/ready byte stream of the snapshot
//   busy, frame_count                  streaming status, completed frame counter
module byte_array_streamer #(
    parameter int NUM_BYTES = 4,
    parameter int SEL_W     = $clog2(NUM_BYTES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BYTES*8-1:0] data_word,
    input  logic                   write_enable,
    input  logic [NUM_BYTES-1:0]   byte_strobe,
    input  logic [SEL_W-1:0]       byte_select,
    output logic [7:0]             selected_byte,
    output logic                   byte_parity,
    output logic [3:0]             nibble_high,
    output logic [3:0]             nibble_low,
    output logic                   word_parity,
    input  logic                   start,
    input  logic                   msb_first,
    output logic [7:0]             stream_byte,
    output logic                   stream_parity,
    output logic                   stream_valid,
    input  logic                   stream_ready,
    output logic                   stream_last,
    output logic                   busy,
    output logic [15:0]            frame_count
);
    localparam logic [0:0]       STATE_IDLE   = 1'b0;
    localparam logic [0:0]       STATE_STREAM = 1'b1;
    localparam logic [SEL_W-1:0] LAST_INDEX   = SEL_W'(NUM_BYTES - 1);
    localparam logic [SEL_W:0]   BYTE_COUNT   = (SEL_W + 1)'(NUM_BYTES);
    logic [NUM_BYTES-1:0][7:0] storage;
    logic [NUM_BYTES-1:0][7:0] snapshot;
    logic [0:0]                state;
    logic [SEL_W-1:0]          stream_index;
    logic                      order_msb;
    logic                      streaming;
    logic                      transfer;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            storage <= '0;
        end else if (write_enable) begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (byte_strobe[i]) storage[i] <= data_word[8*i +: 8];
        end
    end
    // Select values past the last byte only exist for non-power-of-two sizes; they read as zero.
    assign selected_byte = ({1'b0, byte_select} < BYTE_COUNT) ? storage[byte_select] : 8'h00;
    assign byte_parity   = ^selected_byte;
    assign nibble_high   = selected_byte[7:4];
    assign nibble_low    = selected_byte[3:0];
    assign word_parity   = ^storage;
    assign streaming     = (state == STATE_STREAM);
    assign busy          = streaming;
    assign stream_valid  = streaming;
    assign transfer      = streaming && stream_ready;
    assign stream_byte   = streaming ? snapshot[stream_index] : 8'h00;
    assign stream_parity = ^stream_byte;
    assign stream_last   = streaming && (order_msb ? (stream_index == '0) : (stream_index == LAST_INDEX));
    // The snapshot takes the registered storage, so a write landing on the start edge is not in the frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= STATE_IDLE;
            snapshot     <= '0;
            stream_index <= '0;
            order_msb    <= 1'b0;
            frame_count  <= 16'h0000;
        end else if (!streaming) begin
            if (start) begin
                state        <= STATE_STREAM;
                snapshot     <= storage;
                order_msb    <= msb_first;
                stream_index <= msb_first ? LAST_INDEX : '0;
            end
        end else if (transfer) begin
            if (stream_last) begin
                state       <= STATE_IDLE;
                frame_count <= frame_count + 16'd1;
            end else begin
                stream_index <= order_msb ? stream_index - SEL_W'(1) : stream_index + SEL_W'(1);
            end
        end
    end
endmodule
